// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage of the RV32I core. Accepts one load/store per request and runs
//   it on a req/gnt/rvalid data bus with byte lanes. Misaligned accesses are split
//   into two aligned beats when ALLOW_MISALIGNED=1. Load data is merged across beats,
//   then sign/zero-extended. A one-cycle done pulse, with err, ends every access.
//
//   Ports
//     clock, reset_n     rising-edge clock, asynchronous active-low reset
//     req_valid/ready    request handshake (ready = IDLE)
//     addr, store_data   byte address and size-aligned store value
//     mem_wEn, wb_sel    0 = store / 1 = load (store wins)
//     MemSize            00 byte, 01 half, 10 word, 11 illegal
//     load_extend_sign   1 = sign-extend load result
//     done, err          end-of-access pulse and its error flag
//     load_data          extended load result, held until the next successful load
//     dbus_*             data bus master (word-aligned address, byte enables)
//
//   Timing: dbus_rvalid/dbus_rdata are registered at the bus boundary. An aligned
//   access with immediate gnt and rvalid one cycle later pulses done on the fourth
//   rising edge after the accept edge.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES   = 256,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        mem_wEn,
    input  logic        wb_sel,
    input  logic [1:0]  MemSize,
    input  logic        load_extend_sign,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = raw[7:0];
        h = raw[15:0];
        r = raw;
        case (size)
            2'b00:   r = sgn ? 32'(b) : {24'h0, raw[7:0]};
            2'b01:   r = sgn ? 32'(h) : {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    state_t state, state_nx;

    logic        accept, is_store_in, is_load_in, is_mem_in, misal_in, bad_in;
    logic [1:0]  k_in;
    logic [3:0]  be0_in;

    logic [1:0]  k_p0, size_p0;
    logic [31:0] sdata_p0;
    logic        sign_p0, load_p0, split_p0, err_p0;

    logic [31:0] rdata0_p1, rdata1_p1;
    logic        vld_p1;

    logic [CNT_W-1:0] tmo_cnt;
    logic        in_req, in_wait, tmo_hit, tmo_fire;
    logic [3:0]  be1;
    logic [31:0] wdata1, raw_ld;

    assign req_ready   = (state == S_IDLE);
    assign accept      = req_valid & req_ready;
    assign is_store_in = ~mem_wEn;
    assign is_load_in  = mem_wEn & wb_sel;
    assign is_mem_in   = is_store_in | is_load_in;
    assign k_in        = addr[1:0];
    assign misal_in    = ((MemSize == 2'b01) && (k_in == 2'd3)) ||
                         ((MemSize == 2'b10) && (k_in != 2'd0));
    assign bad_in      = (MemSize == 2'b11) || (misal_in && !ALLOW_MISALIGNED);
    assign be0_in      = 4'({4'b0000, size_mask(MemSize)} << k_in);

    // Second beat carries the lanes that spilled past the word boundary.
    assign be1    = size_mask(size_p0) >> (3'd4 - {1'b0, k_p0});
    assign wdata1 = sdata_p0 >> (6'd32 - {1'b0, k_p0, 3'b000});
    assign raw_ld = 32'({rdata1_p1, rdata0_p1} >> {k_p0, 3'b000});

    assign in_req   = (state == S_REQ0) || (state == S_REQ1);
    assign in_wait  = (state == S_WAIT0) || (state == S_WAIT1);
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = tmo_hit && ((in_req && !dbus_gnt) || (in_wait && !vld_p1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!is_mem_in || bad_in) state_nx = S_RESP;
                    else                      state_nx = S_REQ0;
                end
            end
            S_REQ0:  if (dbus_gnt) state_nx = S_WAIT0; else if (tmo_fire) state_nx = S_RESP;
            S_WAIT0: begin
                if (vld_p1)        state_nx = split_p0 ? S_REQ1 : S_RESP;
                else if (tmo_fire) state_nx = S_RESP;
            end
            S_REQ1:  if (dbus_gnt) state_nx = S_WAIT1; else if (tmo_fire) state_nx = S_RESP;
            S_WAIT1: if (vld_p1 || tmo_fire) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Wait counter restarts on every state change, so each beat phase gets its own budget.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                           tmo_cnt <= '0;
        else if (state_nx != state)             tmo_cnt <= '0;
        else if ((in_req || in_wait) && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Stage p0: request fields captured at accept
    always_ff @(posedge clock) begin
        if (accept) begin
            k_p0     <= k_in;
            size_p0  <= MemSize;
            sdata_p0 <= store_data;
            sign_p0  <= load_extend_sign;
            load_p0  <= is_load_in;
            split_p0 <= misal_in;
        end
    end

    // Stage p1: bus read data registered alongside vld_p1
    always_ff @(posedge clock) begin
        if (accept)                                 rdata1_p1 <= '0;
        else if (state == S_WAIT1 && dbus_rvalid)   rdata1_p1 <= dbus_rdata;
        if (state == S_WAIT0 && dbus_rvalid)        rdata0_p1 <= dbus_rdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            err_p0     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_data  <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
        end else begin
            vld_p1 <= dbus_rvalid && in_wait;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        err_p0 <= is_mem_in && bad_in;
                        if (is_mem_in && !bad_in) begin
                            dbus_req   <= 1'b1;
                            dbus_we    <= is_store_in;
                            dbus_addr  <= {addr[31:2], 2'b00};
                            dbus_be    <= be0_in;
                            dbus_wdata <= store_data << {k_in, 3'b000};
                        end
                    end
                end
                S_REQ0, S_REQ1: begin
                    if (dbus_gnt || tmo_fire) dbus_req <= 1'b0;
                    if (tmo_fire)             err_p0   <= 1'b1;
                end
                S_WAIT0: begin
                    if (vld_p1 && split_p0) begin
                        dbus_req   <= 1'b1;
                        dbus_addr  <= dbus_addr + 32'd4;
                        dbus_be    <= be1;
                        dbus_wdata <= wdata1;
                    end else if (tmo_fire) begin
                        err_p0 <= 1'b1;
                    end
                end
                S_WAIT1: if (tmo_fire) err_p0 <= 1'b1;
                S_RESP: begin
                    done    <= 1'b1;
                    err     <= err_p0;
                    dbus_we <= 1'b0;
                    if (load_p0 && !err_p0)
                        load_data <= extend_load(raw_ld, size_p0, sign_p0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clock, reset_n;
    logic        req_valid, req_valid2;
    logic        req_ready, req_ready2;
    logic [31:0] addr, store_data;
    logic        mem_wEn, wb_sel, load_extend_sign;
    logic [1:0]  MemSize;
    logic        done, err, done2, err2;
    logic [31:0] load_data, load_data2;
    logic        dbus_req, dbus_we, dbus_req2, dbus_we2;
    logic [31:0] dbus_addr, dbus_wdata, dbus_addr2, dbus_wdata2;
    logic [3:0]  dbus_be, dbus_be2;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        gnt2, rvalid2;
    logic [31:0] rdata2;

    load_store_unit #(.TIMEOUT_CYCLES(256), .ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .store_data(store_data), .mem_wEn(mem_wEn), .wb_sel(wb_sel),
        .MemSize(MemSize), .load_extend_sign(load_extend_sign), .done(done), .err(err),
        .load_data(load_data), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(256), .ALLOW_MISALIGNED(1'b0)) dut_nomis (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .addr(addr), .store_data(store_data), .mem_wEn(mem_wEn), .wb_sel(wb_sel),
        .MemSize(MemSize), .load_extend_sign(load_extend_sign), .done(done2), .err(err2),
        .load_data(load_data2), .dbus_req(dbus_req2), .dbus_we(dbus_we2), .dbus_addr(dbus_addr2),
        .dbus_be(dbus_be2), .dbus_wdata(dbus_wdata2), .dbus_gnt(gnt2),
        .dbus_rvalid(rvalid2), .dbus_rdata(rdata2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // bus responder configuration and beat log
    int          gnt_wait = 0;
    bit          rvalid_en = 1'b1;
    logic [31:0] rd_beat [2];
    int          nbeats = 0;
    int          hold = 0;
    bit          pending = 1'b0;
    bit          stable_bad = 1'b0;
    bit          saw_req2 = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic [31:0] log_addr [4];
    logic [31:0] log_wdata [4];
    logic [3:0]  log_be [4];
    logic        log_we [4];

    int          lat;
    bit          got;
    logic        r_err, r_rdy;
    logic [31:0] r_ld;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got_v, exp_v);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clock);
            if (dbus_req2) saw_req2 = 1'b1;
        end
    end

    // Bus slave: grants after gnt_wait held cycles, answers rvalid one cycle after gnt.
    initial begin
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        forever begin
            @(posedge clock); #1;
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
            if (!reset_n) begin
                pending = 1'b0; hold = 0;
            end else begin
                if (pending) begin
                    dbus_rvalid = rvalid_en;
                    dbus_rdata  = rd_beat[(nbeats >= 2) ? 1 : 0];
                    pending = 1'b0;
                end
                if (dbus_req) begin
                    if (hold == 0) begin
                        h_addr = dbus_addr; h_be = dbus_be; h_wdata = dbus_wdata;
                    end else if (dbus_addr !== h_addr || dbus_be !== h_be || dbus_wdata !== h_wdata) begin
                        stable_bad = 1'b1;
                    end
                    if (hold < gnt_wait) begin
                        hold++;
                    end else begin
                        dbus_gnt = 1'b1;
                        if (nbeats < 4) begin
                            log_addr[nbeats] = dbus_addr; log_be[nbeats] = dbus_be;
                            log_wdata[nbeats] = dbus_wdata; log_we[nbeats] = dbus_we;
                        end
                        nbeats++;
                        pending = 1'b1;
                        hold = 0;
                    end
                end
            end
        end
    end

    // Called at posedge+1; issues one request and waits a bounded number of cycles for done.
    task automatic run_access(input logic [31:0] a, input logic [31:0] sd, input logic wen,
                              input logic wbs, input logic [1:0] sz, input logic sg, input int maxc);
        addr = a; store_data = sd; mem_wEn = wen; wb_sel = wbs; MemSize = sz;
        load_extend_sign = sg; nbeats = 0; stable_bad = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < maxc) begin
            if (done) got = 1'b1;
            else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        if (!got) chk("done_seen", 32'd0, 32'd1);
        r_err = err; r_ld = load_data; r_rdy = req_ready;
        @(posedge clock); #1;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
        addr = '0; store_data = '0; mem_wEn = 1'b1; wb_sel = 1'b0; MemSize = 2'b10;
        load_extend_sign = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
        rd_beat[0] = '0; rd_beat[1] = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_req",   {31'd0, dbus_req}, 32'd0);
        chk("rst_we",    {31'd0, dbus_we}, 32'd0);
        chk("rst_ld",    load_data, 32'd0);
        chk("rst_addr",  dbus_addr, 32'd0);
        chk("rst_be",    {28'd0, dbus_be}, 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // lw aligned
        rd_beat[0] = 32'hDEADBEEF;
        run_access(32'h100, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 20);
        chk("lw_lat", lat, 32'd4);
        chk("lw_beats", nbeats, 32'd1);
        chk("lw_addr", log_addr[0], 32'h100);
        chk("lw_be", {28'd0, log_be[0]}, 32'hF);
        chk("lw_we", {31'd0, log_we[0]}, 32'd0);
        chk("lw_err", {31'd0, r_err}, 32'd0);
        chk("lw_data", r_ld, 32'hDEADBEEF);
        chk("lw_ready_at_done", {31'd0, r_rdy}, 32'd1);

        // lb / lbu top byte
        rd_beat[0] = 32'h80000000;
        run_access(32'h103, 32'h0, 1'b1, 1'b1, 2'b00, 1'b1, 20);
        chk("lb_be", {28'd0, log_be[0]}, 32'h8);
        chk("lb_addr", log_addr[0], 32'h100);
        chk("lb_data", r_ld, 32'hFFFFFF80);
        run_access(32'h103, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 20);
        chk("lbu_data", r_ld, 32'h00000080);

        // sh upper half
        run_access(32'h206, 32'h0000ABCD, 1'b0, 1'b0, 2'b01, 1'b0, 20);
        chk("sh_beats", nbeats, 32'd1);
        chk("sh_addr", log_addr[0], 32'h204);
        chk("sh_be", {28'd0, log_be[0]}, 32'hC);
        chk("sh_wdata", log_wdata[0], 32'hABCD0000);
        chk("sh_we", {31'd0, log_we[0]}, 32'd1);
        chk("sh_err", {31'd0, r_err}, 32'd0);
        chk("sh_ld_hold", r_ld, 32'h00000080);

        // neither load nor store
        run_access(32'h400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 20);
        chk("nop_lat", lat, 32'd1);
        chk("nop_err", {31'd0, r_err}, 32'd0);
        chk("nop_beats", nbeats, 32'd0);
        chk("nop_ld_hold", r_ld, 32'h00000080);

        // illegal size
        run_access(32'h100, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0, 20);
        chk("sz11_err", {31'd0, r_err}, 32'd1);
        chk("sz11_beats", nbeats, 32'd0);
        chk("sz11_ld_hold", r_ld, 32'h00000080);

        // misaligned lw split
        rd_beat[0] = 32'h33221100; rd_beat[1] = 32'h00000044;
        run_access(32'h101, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 30);
        chk("mlw_beats", nbeats, 32'd2);
        chk("mlw_addr0", log_addr[0], 32'h100);
        chk("mlw_be0", {28'd0, log_be[0]}, 32'hE);
        chk("mlw_addr1", log_addr[1], 32'h104);
        chk("mlw_be1", {28'd0, log_be[1]}, 32'h1);
        chk("mlw_lat", lat, 32'd7);
        chk("mlw_data", r_ld, 32'h44332211);

        // misaligned sw split
        run_access(32'h102, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 30);
        chk("msw_be0", {28'd0, log_be[0]}, 32'hC);
        chk("msw_wd0", log_wdata[0], 32'h33440000);
        chk("msw_addr1", log_addr[1], 32'h104);
        chk("msw_be1", {28'd0, log_be[1]}, 32'h3);
        chk("msw_wd1", log_wdata[1], 32'h00001122);
        chk("msw_ld_hold", r_ld, 32'h44332211);

        // misaligned lh across the boundary, sign-extended
        rd_beat[0] = 32'hAB000000; rd_beat[1] = 32'h000000CD;
        run_access(32'h103, 32'h0, 1'b1, 1'b1, 2'b01, 1'b1, 30);
        chk("mlh_be0", {28'd0, log_be[0]}, 32'h8);
        chk("mlh_be1", {28'd0, log_be[1]}, 32'h1);
        chk("mlh_data", r_ld, 32'hFFFFCDAB);

        // ALLOW_MISALIGNED=0 instance rejects misaligned lw
        addr = 32'h101; mem_wEn = 1'b1; wb_sel = 1'b1; MemSize = 2'b10; saw_req2 = 1'b0;
        req_valid2 = 1'b1;
        @(posedge clock); #1;
        req_valid2 = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            if (done2) got = 1'b1;
            else begin @(posedge clock); #1; lat++; end
        end
        chk("nomis_done", {31'd0, got}, 32'd1);
        chk("nomis_err", {31'd0, err2}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        chk("nomis_noreq", {31'd0, saw_req2}, 32'd0);

        // gnt withheld 5 cycles
        gnt_wait = 5;
        run_access(32'h300, 32'h12345678, 1'b0, 1'b0, 2'b10, 1'b0, 40);
        chk("hold_stable", {31'd0, stable_bad}, 32'd0);
        chk("hold_lat", lat, 32'd9);
        chk("hold_addr", log_addr[0], 32'h300);
        chk("hold_wdata", log_wdata[0], 32'h12345678);
        gnt_wait = 0;

        // no rvalid: timeout
        rvalid_en = 1'b0;
        run_access(32'h100, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 400);
        chk("tmo_err", {31'd0, r_err}, 32'd1);
        chk("tmo_lat", lat, 32'd258);
        chk("tmo_ld_hold", r_ld, 32'hFFFFCDAB);

        // reset while waiting for rvalid
        addr = 32'h100; mem_wEn = 1'b1; wb_sel = 1'b1; MemSize = 2'b10;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mrst_req", {31'd0, dbus_req}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_ready", {31'd0, req_ready}, 32'd1);
        chk("mrst_ld", load_data, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1; rvalid_en = 1'b1;
        @(posedge clock); #1;
        chk("post_ready", {31'd0, req_ready}, 32'd1);
        rd_beat[0] = 32'hCAFEF00D;
        run_access(32'h10, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 20);
        chk("post_lat", lat, 32'd4);
        chk("post_err", {31'd0, r_err}, 32'd0);
        chk("post_data", r_ld, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
